uart_rx_sequencer: RTL and testbench
====================================

UART_RX_SEQUENCER -- requirements
Module: uart_rx_sequencer

Interface
REQ-001 The block SHALL have parameter CLKDIV_W, default 26, the width of the clkdiv port.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, the data bits per frame, sent LSB first.
REQ-003 Port clock_in SHALL be: input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 Port reset_n SHALL be: input, 1 bit, synchronous active-low reset.
REQ-005 Port clkdiv SHALL be: input, CLKDIV_W bits, tick divisor; 4x-oversample tick period = clkdiv+1 clocks.
REQ-006 Port rx SHALL be: input, 1 bit, asynchronous serial line, idle high.
REQ-007 Port data_out SHALL be: output, DATA_BITS bits, last correctly framed byte.
REQ-008 Port data_valid SHALL be: output, 1 bit, one-cycle pulse when data_out is updated.
REQ-009 Port frame_error SHALL be: output, 1 bit, one-cycle pulse on a stop bit sampled low.
REQ-010 Port busy SHALL be: output, 1 bit, high in any state other than IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rxs and its 1-cycle delayed copy rxd.
REQ-012 Start detect SHALL be the condition in IDLE: rxd==1 and rxs==0.
REQ-013 On start detect, the block SHALL load the following values: clkdiv into div_q, tick counter to 0, phase to 0, bit index to 0, state to START; clkdiv changes after this cycle SHALL NOT affect the current frame.
REQ-014 Outside IDLE, the tick counter SHALL count 0..div_q; a tick occurs in the cycle where it equals div_q, and the counter then wraps to 0.
REQ-015 Phase (2 bits) SHALL increment on every tick and wrap 3->0; one bit period = 4*(div_q+1) clocks.
REQ-016 Sampling SHALL occur on a tick with phase==1, i.e. 2*(div_q+1) clocks after start detect, at mid-bit.
REQ-017 Bit advance SHALL occur on a tick with phase==3.
REQ-018 The state machine SHALL have states IDLE, START, DATA, STOP; no other states are legal, and an illegal encoding SHALL return to IDLE.
REQ-019 In START, a sample of rxs==1 SHALL be treated as a false start: the block SHALL go to IDLE with no output pulse; otherwise it SHALL go to DATA on the next bit advance.
REQ-020 In DATA, each sample SHALL shift rxs into the shift register at position bit index (LSB first); after the DATA_BITS-th bit advance the block SHALL go to STOP.
REQ-021 In STOP, the sample SHALL end the frame, and the block SHALL go to IDLE in the following cycle without waiting for a bit advance.
REQ-022 If the stop sample is 1, the block SHALL update data_out with the shift register and pulse data_valid for exactly one cycle, in the cycle after the stop sample.
REQ-023 If the stop sample is 0, the block SHALL pulse frame_error for exactly one cycle with the same timing, and data_out SHALL be unchanged.
REQ-024 After a frame error with rx held low, no new frame SHALL start until rx returns high and falls again.
REQ-025 Back-to-back frames SHALL be received with no idle gap beyond the stop bit, because the block returns to IDLE at mid-stop-bit.
REQ-026 data_valid and frame_error SHALL never be high in the same cycle.
REQ-027 With clkdiv==0, a tick SHALL occur every clock, giving a 4-clock bit period; this case is legal.
REQ-028 busy SHALL be high from the cycle after start detect through the stop-sample cycle.

Reset
REQ-029 While reset_n is low at a clock edge, the block SHALL set state=IDLE, data_out=0, data_valid=0, frame_error=0, busy=0, tick counter, phase and bit index all 0, and both synchronizer flops and rxd to 1.
REQ-030 Reset SHALL take priority over all other events, including a tick, start detect, or stop sample in the same cycle.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no data_valid or frame_error pulse.

Verification
REQ-032 clkdiv=3 (16-clock bit), send 0xA5 with stop=1 -> exactly one data_valid pulse, data_out=0xA5, frame_error never high.
REQ-033 Low glitch of 4 clocks on idle line, clkdiv=3 -> START sample reads 1, back to IDLE, busy drops, no pulses.
REQ-034 Send 0x3C with stop=0 after a good 0xA5 -> one frame_error pulse, data_out stays 0xA5.
REQ-035 clkdiv=0, back-to-back frames 0x00 then 0xFF with no gap -> two data_valid pulses with data_out 0x00 then 0xFF.
REQ-036 Change clkdiv 3->7 in the middle of a 0x5A frame -> 0x5A received at the 16-clock bit timing; the next frame uses 32-clock bits.
REQ-037 Assert reset_n low for 1 cycle during DATA bit 4 -> all outputs 0 next cycle, no pulses, and the next full frame is received correctly.

Source files
------------

// File: rtl/uart_rx_sequencer.sv
// uart_rx_sequencer
// -----------------
// Receives asynchronous serial frames (one start bit, DATA_BITS data bits
// sent LSB first, one stop bit) using a 4x-oversample tick. Each bit period
// is split into four tick phases: phase 1 samples the line at mid-bit and
// phase 3 advances to the next bit. The frame ends at the stop-bit sample,
// so the receiver is back in IDLE halfway through the stop bit and can catch
// a start bit that follows immediately.
//
// Ports
//   clock_in    : single clock, rising edge
//   reset_n     : synchronous active-low reset
//   clkdiv      : tick divisor; tick period = clkdiv+1 clocks, latched at start
//   rx          : asynchronous serial input, idle high
//   data_out    : last correctly framed word
//   data_valid  : one-cycle pulse when data_out is updated
//   frame_error : one-cycle pulse when the stop bit is sampled low
//   busy        : high whenever a frame is in progress
module uart_rx_sequencer #(
  parameter int CLKDIV_W  = 26,
  parameter int DATA_BITS = 8
) (
  input  logic                 clock_in,
  input  logic                 reset_n,
  input  logic [CLKDIV_W-1:0]  clkdiv,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 frame_error,
  output logic                 busy
);

  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 sync1_q;
  logic                 rxs_q;
  logic                 rxd_q;
  logic [CLKDIV_W-1:0]  div_q, div_d;
  logic [CLKDIV_W-1:0]  cnt_q, cnt_d;
  logic [1:0]           phase_q, phase_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;

  logic start_det;
  logic tick;
  logic sample;
  logic advance;

  // Falling edge of the synchronized line while idle. After a frame error
  // with the line held low, rxd and rxs are both 0, so nothing restarts
  // until the line goes high and falls again.
  assign start_det = (state_q == IDLE) && rxd_q && !rxs_q;
  assign tick      = (state_q != IDLE) && (cnt_q == div_q);
  assign sample    = tick && (phase_q == 2'd1);
  assign advance   = tick && (phase_q == 2'd3);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;

    if (state_q != IDLE) begin
      if (tick) begin
        cnt_d   = '0;
        phase_d = phase_q + 2'd1;
      end else begin
        cnt_d   = cnt_q + CLKDIV_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (start_det) begin
          // Divisor is captured here so later clkdiv changes only affect
          // the next frame.
          div_d     = clkdiv;
          cnt_d     = '0;
          phase_d   = 2'd0;
          bit_idx_d = '0;
          state_d   = START;
        end
      end
      START: begin
        if (sample && rxs_q) begin
          state_d = IDLE;            // glitch, not a real start bit
        end else if (advance) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (sample) begin
          shift_d[bit_idx_q] = rxs_q;
        end
        if (advance) begin
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      STOP: begin
        if (sample) begin
          state_d = IDLE;
          if (rxs_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b1;
      rxs_q     <= 1'b1;
      rxd_q     <= 1'b1;
      div_q     <= '0;
      cnt_q     <= '0;
      phase_q   <= 2'd0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= rx;
      rxs_q     <= sync1_q;
      rxd_q     <= rxs_q;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign frame_error = ferr_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Testbench for uart_rx_sequencer: directed scenarios plus random frames,
// checked by a scoreboard that predicts each output pulse (kind, data and
// arrival cycle) from the line-level frame description.
module tb_uart_rx_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [25:0] clkdiv;
  logic        rx;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        frame_error;
  logic        busy;

  always #5 clk = ~clk;

  uart_rx_sequencer #(.CLKDIV_W(26), .DATA_BITS(8)) dut (
    .clock_in   (clk),
    .reset_n    (reset_n),
    .clkdiv     (clkdiv),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_error(frame_error),
    .busy       (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: a frame whose stop bit is 1 delivers its data;
  // otherwise it flags a frame error and data_out keeps the last good word.
  // Pulse cycle: rx falls before edge n=c+1, two sync flops put the falling
  // edge on rxs, start detect registers at n+2, mid-stop sample comes
  // 2(d+1)+9*4(d+1) clocks later and the pulse is visible after that edge.
  task automatic send_frame(input logic [7:0] data, input bit stop, input int d);
    int         b;
    logic [9:0] bits;
    b      = 4 * (d + 1);
    bits   = {stop, data, 1'b0};
    clkdiv = 26'(d);
    if (stop) begin
      last_good = data;
      exp_q.push_back('{1'b0, data, cyc + 38 * (d + 1) + 3});
    end else begin
      exp_q.push_back('{1'b1, last_good, cyc + 38 * (d + 1) + 3});
    end
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (b) @(negedge clk);
    end
  endtask

  // Monitor: every output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (data_valid || frame_error) begin
      chk("pulse_exclusive", 32'(data_valid && frame_error), 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse dv=%0b fe=%0b data_out=%02h required=none (cycle %0d)",
                 data_valid, frame_error, data_out, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_kind", 32'(frame_error), 32'(mon_e.err));
        chk("data_out", 32'(data_out), 32'(mon_e.data));
        chk("pulse_cycle", 32'(cyc), 32'(mon_e.cyc));
        $display("rx %s data_out=%02h cycle=%0d", frame_error ? "frame_error" : "data_valid",
                 data_out, cyc);
      end
    end
  end

  initial begin
    logic [7:0] rd;
    bit         rs;
    int         rdiv;
    int         gap;
    logic [7:0] abort_data;

    reset_n = 1'b0;
    rx      = 1'b1;
    clkdiv  = 26'd3;
    repeat (3) @(negedge clk);
    chk("reset_data_out", 32'(data_out), 32'd0);
    chk("reset_data_valid", 32'(data_valid), 32'd0);
    chk("reset_frame_error", 32'(frame_error), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Good frame at 16-clock bits.
    send_frame(8'hA5, 1'b1, 3);
    rx = 1'b1;
    repeat (8) @(negedge clk);

    // 4-clock low glitch: false start, busy rises then drops, no pulse.
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_high", 32'(busy), 32'd1);
    repeat (20) @(negedge clk);
    chk("glitch_busy_low", 32'(busy), 32'd0);

    // Bad stop bit, then line held low: one frame error, no restart.
    send_frame(8'h3C, 1'b0, 3);
    repeat (48) @(negedge clk);
    chk("held_low_busy", 32'(busy), 32'd0);
    chk("data_after_ferr", 32'(data_out), 32'hA5);
    rx = 1'b1;
    repeat (16) @(negedge clk);

    // Back-to-back frames at the fastest rate.
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    rx = 1'b1;
    repeat (8) @(negedge clk);

    // Divisor changed mid-frame only affects the following frame.
    fork
      send_frame(8'h5A, 1'b1, 3);
      begin
        repeat (80) @(negedge clk);
        clkdiv = 26'd7;
      end
    join
    rx = 1'b1;
    repeat (40) @(negedge clk);
    send_frame(8'hC3, 1'b1, 7);
    rx = 1'b1;
    repeat (16) @(negedge clk);

    // Reset pulse in the middle of data bit 4 aborts the frame.
    clkdiv     = 26'd3;
    abort_data = 8'h6B;
    rx         = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = abort_data[i];
      repeat (16) @(negedge clk);
    end
    rx = abort_data[4];
    repeat (8) @(negedge clk);
    chk("busy_before_abort", 32'(busy), 32'd1);
    reset_n = 1'b0;
    rx      = 1'b1;
    @(negedge clk);
    reset_n   = 1'b1;
    last_good = 8'h00;
    chk("abort_data_out", 32'(data_out), 32'd0);
    chk("abort_data_valid", 32'(data_valid), 32'd0);
    chk("abort_frame_error", 32'(frame_error), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (40) @(negedge clk);
    send_frame(8'h96, 1'b1, 3);
    rx = 1'b1;
    repeat (16) @(negedge clk);

    // Random frames with random divisors, stop bits and gaps.
    for (int n = 0; n < 12; n++) begin
      rd   = 8'($urandom);
      rs   = ($urandom_range(0, 4) != 0);
      rdiv = int'($urandom_range(0, 4));
      send_frame(rd, rs, rdiv);
      rx = 1'b1;
      gap = rs ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 6));
      repeat (gap) @(negedge clk);
    end
    rx = 1'b1;

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    repeat (10) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
